// File: rtl/entropy_bitstream_reader.sv
// Receive side of the entropy bitstream: 0..5 bytes/cycle into a byte FIFO, refilling an MSB-aligned bit window.
// Define READER_STATS_EN to add out_byte_count (bytes moved into the window, saturating).
module entropy_bitstream_reader #(
  parameter int RD_BITSTREAM_WIDTH = 8,
  parameter int RD_WINDOW_WIDTH    = 32,
  parameter int RD_D_SIZE          = 5,
  parameter int RD_FIFO_ADDR_WIDTH = 4
) (
  input  logic                          top_clk,
  input  logic                          top_reset,
  input  logic [RD_BITSTREAM_WIDTH-1:0] in_bit_1,
  input  logic [RD_BITSTREAM_WIDTH-1:0] in_bit_2,
  input  logic [RD_BITSTREAM_WIDTH-1:0] in_bit_3,
  input  logic [RD_BITSTREAM_WIDTH-1:0] in_bit_4,
  input  logic [RD_BITSTREAM_WIDTH-1:0] in_bit_5,
  input  logic [2:0]                    in_flag_bitstream,
  input  logic                          in_flag_last,
  output logic                          out_ready,
  input  logic                          in_shift_en,
  input  logic [RD_D_SIZE-1:0]          in_shift_amount,
  output logic [RD_WINDOW_WIDTH-1:0]    out_window,
  output logic [RD_D_SIZE:0]            out_window_cnt,
  output logic                          out_window_valid,
  output logic                          out_end,
  output logic                          out_error
`ifdef READER_STATS_EN
  ,
  output logic [31:0]                   out_byte_count
`endif
);
  localparam int BW        = RD_BITSTREAM_WIDTH;
  localparam int W         = RD_WINDOW_WIDTH;
  localparam int AW        = RD_FIFO_ADDR_WIDTH;
  localparam int DEPTH     = 1 << AW;
  localparam int NUM_LANES = 5;
  localparam int CW        = RD_D_SIZE + 1;
  localparam int MAX_SHIFT = 16;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   occ_t;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [2:0] {IDLE, FILL, STREAM, DRAIN, PAD} state_t;

  state_t state, state_n;

  logic [BW-1:0]                 mem [DEPTH];
  ptr_t                          wr_ptr, rd_ptr;
  occ_t                          occ, occ_n;
  logic [W-1:0]                  window, win_s, win_n;
  cnt_t                          cnt, cnt_s, cnt_1, cnt_n, amt;
  logic                          last_seen, error;
  logic [NUM_LANES-1:0][BW-1:0]  lane;
  logic [NUM_LANES-1:0]          lane_we;
  logic                          beat, accept, wr_err, shift_ok, sh_err, pop_1, pop_2;
  logic [2:0]                    n_push;
  logic [1:0]                    n_pop;

  assign lane = {in_bit_5, in_bit_4, in_bit_3, in_bit_2, in_bit_1};
  assign amt  = cnt_t'(in_shift_amount);

  // Write side: a beat is any non-zero count or a last flag (count 0 + last = end marker).
  assign beat   = (in_flag_bitstream != 3'd0) || in_flag_last;
  assign accept = beat && (in_flag_bitstream <= 3'd5) && out_ready && !last_seen;
  assign wr_err = beat && !accept;
  assign n_push = accept ? in_flag_bitstream : 3'd0;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_we[g] = (3'(g) < n_push);
  end

  assign out_window_valid = (cnt >= cnt_t'(MAX_SHIFT)) || (state == PAD);
  assign shift_ok = in_shift_en && out_window_valid && (amt <= cnt_t'(MAX_SHIFT));
  assign sh_err   = in_shift_en && !shift_ok;

  // Shift first, then top up with at most two bytes from the pre-cycle FIFO contents.
  always_comb begin
    win_s = window;
    cnt_s = cnt;
    if (shift_ok) begin
      win_s = window << in_shift_amount;
      cnt_s = (cnt > amt) ? cnt - amt : '0;
    end
    pop_1 = (occ != '0) && (int'(cnt_s) + BW <= W);
    cnt_1 = pop_1 ? cnt_s + cnt_t'(BW) : cnt_s;
    pop_2 = pop_1 && (occ >= occ_t'(2)) && (int'(cnt_1) + BW <= W);
    cnt_n = pop_2 ? cnt_1 + cnt_t'(BW) : cnt_1;
    win_n = win_s;
    if (pop_1) win_n = win_n | ({mem[rd_ptr], {(W-BW){1'b0}}} >> cnt_s);
    if (pop_2) win_n = win_n | ({mem[rd_ptr + ptr_t'(1)], {(W-BW){1'b0}}} >> cnt_1);
    n_pop = {1'b0, pop_1} + {1'b0, pop_2};
    occ_n = occ + occ_t'(n_push) - occ_t'(n_pop);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept && in_flag_last) state_n = DRAIN;
        else if (accept)            state_n = FILL;
      end
      FILL: begin
        if (accept && in_flag_last)          state_n = DRAIN;
        else if (cnt_n >= cnt_t'(MAX_SHIFT)) state_n = STREAM;
      end
      STREAM: begin
        if (accept && in_flag_last)         state_n = DRAIN;
        else if (cnt_n < cnt_t'(MAX_SHIFT)) state_n = FILL;
      end
      DRAIN:   if (occ_n == '0) state_n = PAD;
      default: state_n = state;
    endcase
  end

  always_ff @(posedge top_clk) begin
    if (top_reset) state <= IDLE;
    else           state <= state_n;
  end

  always_ff @(posedge top_clk) begin
    if (!top_reset) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (lane_we[i]) mem[wr_ptr + ptr_t'(i)] <= lane[i];
    end
  end

  always_ff @(posedge top_clk) begin
    if (top_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      window    <= '0;
      cnt       <= '0;
      out_ready <= 1'b1;
      last_seen <= 1'b0;
      error     <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + ptr_t'(n_push);
      rd_ptr    <= rd_ptr + ptr_t'(n_pop);
      occ       <= occ_n;
      window    <= win_n;
      cnt       <= cnt_n;
      out_ready <= (occ_t'(DEPTH) - occ_n) >= occ_t'(NUM_LANES);
      last_seen <= last_seen | (accept & in_flag_last);
      error     <= error | wr_err | sh_err;
    end
  end

  assign out_window     = window;
  assign out_window_cnt = cnt;
  assign out_end        = (state == PAD) && (cnt == '0);
  assign out_error      = error;

`ifdef READER_STATS_EN
  logic [32:0] bc_sum;
  assign bc_sum = {1'b0, out_byte_count} + 33'(n_pop);

  always_ff @(posedge top_clk) begin
    if (top_reset) out_byte_count <= '0;
    else           out_byte_count <= bc_sum[32] ? '1 : bc_sum[31:0];
  end
`endif

endmodule
